// File: rtl/pfb_pkg.sv
// Shared constants and helpers for the ping-pong frame buffer and the game top
// that instantiates it.
package pfb_pkg;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_t;

    localparam int PFB_DATA_W = 8;
    localparam int PFB_DEPTH  = 160;

    // Address width for a bank of the given depth; never narrower than one bit.
    function automatic int pfb_addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/pingpong_frame_buffer_if.sv
// Writer/reader bus of the ping-pong frame buffer; master is the producer and
// scan-out side, slave is the buffer itself.
interface pingpong_frame_buffer_if #(
    parameter int DATA_W = pfb_pkg::PFB_DATA_W,
    parameter int DEPTH  = pfb_pkg::PFB_DEPTH
);
    localparam int ADDR_W = pfb_pkg::pfb_addr_w(DEPTH);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_commit;
    logic              wr_ready;
    logic              frame_start;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output wr_en, wr_addr, wr_data, wr_commit, frame_start, rd_en, rd_addr,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_commit, frame_start, rd_en, rd_addr,
        output wr_ready, rd_data, rd_valid
    );

endinterface

// File: rtl/pfb_sdp_ram.sv
// Simple dual-port RAM: one write port and one registered read port. Reads past
// DEPTH return zero; only the read register is reset, never the array.
module pfb_sdp_ram
    import pfb_pkg::*;
#(
    parameter int DATA_W = PFB_DATA_W,
    parameter int DEPTH  = PFB_DEPTH,
    parameter int ADDR_W = pfb_addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              waddr_ok;
    logic              raddr_ok;

    assign waddr_ok = {1'b0, waddr} < DEPTH_LIM;
    assign raddr_ok = {1'b0, raddr} < DEPTH_LIM;

    always_ff @(posedge clk) begin
        if (we && waddr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= raddr_ok ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/pingpong_frame_buffer.sv
// Two-bank frame buffer: the producer fills the back bank and commits, and the
// banks swap only at a reader frame boundary so scan-out never tears.
module pingpong_frame_buffer
    import pfb_pkg::*;
#(
    parameter int DATA_W = PFB_DATA_W,
    parameter int DEPTH  = PFB_DEPTH,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    pingpong_frame_buffer_if.slave bus,
    output logic                   front_sel,
    output logic                   swap_pulse,
    output logic [CNT_W-1:0]       overrun_cnt
);
    localparam int ADDR_W = pfb_addr_w(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    bank_t             front_bank;
    bank_t             rd_bank;
    logic              pending;
    logic              rd_valid_q;
    logic              wr_in_range;
    logic              wr_accept;
    logic              commit_accept;
    logic              rejected;
    logic              do_swap;
    logic              we0;
    logic              we1;
    logic [DATA_W-1:0] q0;
    logic [DATA_W-1:0] q1;

    // While a committed frame waits for the swap, the back bank is frozen.
    assign wr_in_range   = {1'b0, bus.wr_addr} < DEPTH_LIM;
    assign wr_accept     = bus.wr_en & ~pending & wr_in_range;
    assign commit_accept = bus.wr_commit & ~pending;
    assign rejected      = (bus.wr_en | bus.wr_commit) & pending;
    assign do_swap       = bus.frame_start & pending;

    assign we0 = wr_accept & (front_bank == BANK1);
    assign we1 = wr_accept & (front_bank == BANK0);

    assign bus.wr_ready = ~pending;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = (rd_bank == BANK1) ? q1 : q0;
    assign front_sel    = front_bank;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            front_bank  <= BANK0;
            rd_bank     <= BANK0;
            pending     <= 1'b0;
            swap_pulse  <= 1'b0;
            rd_valid_q  <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            swap_pulse <= do_swap;
            rd_valid_q <= bus.rd_en;
            // The read mux follows the bank that was front when the read was issued.
            if (bus.rd_en) begin
                rd_bank <= front_bank;
            end
            if (do_swap) begin
                front_bank <= (front_bank == BANK0) ? BANK1 : BANK0;
                pending    <= 1'b0;
            end else if (commit_accept) begin
                pending <= 1'b1;
            end
            if (rejected && overrun_cnt != CNT_MAX) begin
                overrun_cnt <= overrun_cnt + CNT_W'(1);
            end
        end
    end

    pfb_sdp_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) ram0 (
        .clk   (clk),
        .resetn(resetn),
        .we    (we0),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .re    (bus.rd_en),
        .raddr (bus.rd_addr),
        .rdata (q0)
    );

    pfb_sdp_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) ram1 (
        .clk   (clk),
        .resetn(resetn),
        .we    (we1),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .re    (bus.rd_en),
        .raddr (bus.rd_addr),
        .rdata (q1)
    );

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Bench for pingpong_frame_buffer: directed scenarios with literal expectations
// followed by random traffic compared every cycle against a frame-level model.
module tb_pingpong_frame_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 160;
    localparam int CNT_W  = 2;
    localparam int ADDR_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             resetn;
    logic             front_sel;
    logic             swap_pulse;
    logic [CNT_W-1:0] overrun_cnt;

    int checks_total;
    int checks_passed;

    pingpong_frame_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    pingpong_frame_buffer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .front_sel  (front_sel),
        .swap_pulse (swap_pulse),
        .overrun_cnt(overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level model: two banks, which one is shown, and whether a frame waits.
    logic [DATA_W-1:0] m_mem   [2][DEPTH];
    bit                m_known [2][DEPTH];
    int                m_front;
    bit                m_pending;
    int                m_ovr;
    bit                m_swap;
    bit                m_rd_valid;
    logic [DATA_W-1:0] m_rd_data;
    bit                m_rd_known;
    bit                m_init;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!resetn) begin
            m_front    = 0;
            m_pending  = 0;
            m_ovr      = 0;
            m_swap     = 0;
            m_rd_valid = 0;
            m_rd_data  = '0;
            m_rd_known = 1;
            m_init     = 1;
        end else if (m_init) begin
            if (bus.rd_en) begin
                m_rd_valid = 1;
                if (int'(bus.rd_addr) >= DEPTH) begin
                    m_rd_data  = '0;
                    m_rd_known = 1;
                end else begin
                    m_rd_data  = m_mem[m_front][bus.rd_addr];
                    m_rd_known = m_known[m_front][bus.rd_addr];
                end
            end else begin
                m_rd_valid = 0;
            end
            if ((bus.wr_en || bus.wr_commit) && m_pending) begin
                if (m_ovr < CNT_MAX) m_ovr = m_ovr + 1;
            end
            if (bus.wr_en && !m_pending && int'(bus.wr_addr) < DEPTH) begin
                m_mem[1 - m_front][bus.wr_addr]   = bus.wr_data;
                m_known[1 - m_front][bus.wr_addr] = 1;
            end
            m_swap = bus.frame_start && m_pending;
            if (m_swap) begin
                m_front   = 1 - m_front;
                m_pending = 0;
            end else if (bus.wr_commit && !m_pending) begin
                m_pending = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            checkOutput("wr_ready", 32'(bus.wr_ready), 32'(!m_pending));
            checkOutput("front_sel", 32'(front_sel), 32'(m_front));
            checkOutput("swap_pulse", 32'(swap_pulse), 32'(m_swap));
            checkOutput("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
            checkOutput("rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
            if (m_rd_known) begin
                checkOutput("rd_data", 32'(bus.rd_data), 32'(m_rd_data));
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                                 input logic wc, input logic fs, input logic re, input logic [ADDR_W-1:0] ra);
        bus.wr_en       = we;
        bus.wr_addr     = wa;
        bus.wr_data     = wd;
        bus.wr_commit   = wc;
        bus.frame_start = fs;
        bus.rd_en       = re;
        bus.rd_addr     = ra;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        resetn = 1'b0;
        idle();
        idle();
        resetn = 1'b1;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        m_init        = 0;
        resetn        = 1'b0;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.wr_commit = 0;
        bus.frame_start = 0; bus.rd_en = 0; bus.rd_addr = 0;

        // Reset state and first read latency.
        doReset();
        checkOutput("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        checkOutput("rst_rd_data", 32'(bus.rd_data), 32'd0);
        checkOutput("rst_front", 32'(front_sel), 32'd0);
        checkOutput("rst_ready", 32'(bus.wr_ready), 32'd1);
        checkOutput("rst_ovr", 32'(overrun_cnt), 32'd0);
        checkOutput("rst_swap", 32'(swap_pulse), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 5);
        checkOutput("first_rd_valid", 32'(bus.rd_valid), 32'd1);

        // Write, commit, swap, read back.
        applyStimulus(1, 3, 8'h2A, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("commit_ready", 32'(bus.wr_ready), 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("swap_pulse_hi", 32'(swap_pulse), 32'd1);
        checkOutput("swap_front", 32'(front_sel), 32'd1);
        checkOutput("swap_ready", 32'(bus.wr_ready), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 1, 3);
        checkOutput("swap_pulse_lo", 32'(swap_pulse), 32'd0);
        checkOutput("rd_2a", 32'(bus.rd_data), 32'h2A);
        idle();
        checkOutput("rd_idle_valid", 32'(bus.rd_valid), 32'd0);
        checkOutput("rd_hold", 32'(bus.rd_data), 32'h2A);

        // Writes while pending are rejected and counted.
        applyStimulus(1, 7, 8'h11, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 7, 8'h55, 0, 0, 0, 0);
        checkOutput("ovr_ready", 32'(bus.wr_ready), 32'd0);
        checkOutput("ovr_cnt3", 32'(overrun_cnt), 32'd3);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("ovr_front", 32'(front_sel), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 7);
        checkOutput("ovr_rd7", 32'(bus.rd_data), 32'h11);

        // Commit and frame_start together: no swap until the next frame.
        doReset();
        applyStimulus(0, 0, 0, 1, 1, 0, 0);
        checkOutput("cfs_swap", 32'(swap_pulse), 32'd0);
        checkOutput("cfs_front", 32'(front_sel), 32'd0);
        checkOutput("cfs_ready", 32'(bus.wr_ready), 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("cfs_swap2", 32'(swap_pulse), 32'd1);
        checkOutput("cfs_front2", 32'(front_sel), 32'd1);
        applyStimulus(1, 200, 8'h77, 0, 0, 0, 0);
        checkOutput("oor_wr_ovr", 32'(overrun_cnt), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 200);
        checkOutput("oor_rd_data", 32'(bus.rd_data), 32'd0);
        checkOutput("oor_rd_valid", 32'(bus.rd_valid), 32'd1);

        // Read issued in the swap cycle sees the old front bank.
        doReset();
        applyStimulus(1, 1, 8'h20, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 1, 8'h10, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        checkOutput("swapcyc_rd", 32'(bus.rd_data), 32'h10);
        checkOutput("swapcyc_front", 32'(front_sel), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("postswap_rd", 32'(bus.rd_data), 32'h20);

        // Saturation, then reset while a frame is pending on bank1 front.
        doReset();
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 9, 8'hEE, 0, 0, 0, 0);
        checkOutput("sat_cnt", 32'(overrun_cnt), 32'd3);
        checkOutput("sat_front", 32'(front_sel), 32'd1);
        resetn = 1'b0;
        idle();
        checkOutput("midrst_front", 32'(front_sel), 32'd0);
        checkOutput("midrst_ready", 32'(bus.wr_ready), 32'd1);
        checkOutput("midrst_ovr", 32'(overrun_cnt), 32'd0);
        checkOutput("midrst_swap", 32'(swap_pulse), 32'd0);
        resetn = 1'b1;

        // Random traffic, checked each cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            resetn = ($urandom_range(0, 199) != 0);
            applyStimulus(logic'($urandom_range(0, 1)),
                          ADDR_W'($urandom_range(0, 170)),
                          DATA_W'($urandom),
                          logic'($urandom_range(0, 9) == 0),
                          logic'($urandom_range(0, 14) == 0),
                          logic'($urandom_range(0, 4) != 0),
                          ADDR_W'($urandom_range(0, 170)));
        end
        resetn = 1'b1;
        idle();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
